// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions: fetch FSM states, the nop word and the ROM range helper.
// Latency: none (types, constants and functions only).
// Backpressure: none; nothing in this package holds state.
package inst_fetch_pkg;

  // Fetch FSM state encoding.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Instruction word the ROM returns when deselected; it executes as a nop.
  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  // Width of a byte address and of an instruction word.
  localparam int XLEN = 32;

  // A PC can be served by the ROM only if it is word aligned and its byte
  // address fits in the ROM; every other PC fetches a nop.
  function automatic logic pc_fetchable(input logic [31:0] pc, input int addr_w);
    logic in_range;
    logic aligned;
    in_range = ((pc >> (addr_w + 2)) == 32'd0);
    aligned  = (pc[1:0] == 2'b00);
    return in_range && aligned;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched PC, instruction and valid flag.
// Latency: one cycle from load to outputs; reset clears asynchronously.
// Backpressure: holds its contents whenever load, clear and kill are all low.
module if_id_reg
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic        kill,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_ins,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic        valid
);

  // clear squashes the slot to a nop bubble, kill only drops the valid flag
  // (pc and ins stay visible for debug), load captures a new instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= 32'd0;
      ins   <= NOP_INS;
      valid <= 1'b0;
    end else if (clear) begin
      ins   <= NOP_INS;
      valid <= 1'b0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      pc    <= fetch_pc;
      ins   <= fetch_ins;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, ROM addressing and the IF/ID register.
// Latency: one cycle from PC to if_ins; redirect lands in the PC one edge later.
// Backpressure: stall freezes PC and IF/ID; halt stops fetching until reset.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_sel,
  input  logic [31:0]       rom_data,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_ins,
  output logic              if_valid,
  output logic [31:0]       fetch_count,
  output logic              halted
);

  fetch_state_t state;
  logic [31:0]  pc;

  logic         running;
  logic         take_halt;
  logic         take_redirect;
  logic         take_stall;
  logic         advance;

  // ROM is addressed straight from the PC register; it is only selected while
  // actually fetching so that stalled or halted cycles read a nop.
  assign rom_addr = pc[ADDR_W+1:2];
  assign rom_sel  = (state == RUN) && pc_fetchable(pc, ADDR_W);

  // Per-cycle priority: halt, then redirect, then stall, then advance.
  // Once halted nothing but reset has any effect.
  assign running       = (state != HALT);
  assign take_halt     = running && halt;
  assign take_redirect = running && !halt && redirect_valid;
  assign take_stall    = running && !halt && !redirect_valid && stall;
  // The first RUN cycle after a stall only re-presents the held PC to the
  // ROM, so an instruction is fetched only when already in RUN.
  assign advance       = (state == RUN) && !halt && !redirect_valid && !stall;

  // Fetch FSM and PC register; halted is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (take_halt) begin
      state  <= HALT;
      halted <= 1'b1;
    end else if (take_redirect) begin
      state  <= RUN;
      pc     <= redirect_pc;
    end else if (take_stall) begin
      state  <= STALL;
    end else if (state == STALL) begin
      state  <= RUN;
    end else if (advance) begin
      pc     <= pc + 32'd4;
    end
  end

  // Count every instruction latched as valid, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
    end else if (advance) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Out-of-range or misaligned PCs see rom_data == 0 and so latch a valid nop.
  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (advance),
    .clear     (take_redirect),
    .kill      (take_halt),
    .fetch_pc  (pc),
    .fetch_ins (rom_data),
    .pc        (if_pc),
    .ins       (if_ins),
    .valid     (if_valid)
  );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [9:0]  rom_addr;
  logic        rom_sel;
  logic [31:0] rom_data;
  logic [31:0] if_pc;
  logic [31:0] if_ins;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic        halted;

  logic [31:0] rom [0:1023];

  int total;
  int passed;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_ins;
  logic        m_valid;
  logic [31:0] m_cnt;
  logic        m_halted;
  logic        m_stalled;

  inst_fetch #(.RESET_PC(32'h0), .ADDR_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .rom_addr       (rom_addr),
    .rom_sel        (rom_sel),
    .rom_data       (rom_data),
    .if_pc          (if_pc),
    .if_ins         (if_ins),
    .if_valid       (if_valid),
    .fetch_count    (fetch_count),
    .halted         (halted)
  );

  assign rom_data = rom_sel ? rom[rom_addr] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word a 4 KiB, word-aligned fetch would return; anything else is a nop.
  function automatic logic [31:0] m_word(input logic [31:0] a);
    if (a[1:0] == 2'b00 && a < 32'h1000) return rom[a[11:2]];
    return 32'h0;
  endfunction

  function automatic logic m_sel();
    return !m_halted && !m_stalled && (m_pc[1:0] == 2'b00) && (m_pc < 32'h1000);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_if_pc = 0; m_if_ins = 0; m_valid = 0;
    m_cnt = 0; m_halted = 0; m_stalled = 0;
  endtask

  task automatic model_step(input logic h, input logic r, input logic [31:0] rpc, input logic s);
    if (m_halted) begin
      // nothing moves until reset
    end else if (h) begin
      m_halted = 1; m_valid = 0;
    end else if (r) begin
      m_pc = rpc; m_valid = 0; m_if_ins = 0; m_stalled = 0;
    end else if (s) begin
      m_stalled = 1;
    end else if (m_stalled) begin
      m_stalled = 0;
    end else begin
      m_if_pc = m_pc; m_if_ins = m_word(m_pc); m_valid = 1;
      m_cnt = m_cnt + 1; m_pc = m_pc + 4;
    end
  endtask

  // Drive one cycle of inputs from the falling edge, advance the model at the
  // rising edge, return at the next falling edge ready to sample.
  task automatic cycle(input logic h, input logic r, input logic [31:0] rpc, input logic s);
    halt = h; redirect_valid = r; redirect_pc = rpc; stall = s;
    @(posedge clk);
    model_step(h, r, rpc, s);
    @(negedge clk);
  endtask

  task automatic do_reset();
    halt = 0; redirect_valid = 0; redirect_pc = 0; stall = 0;
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc got %h want 0", if_pc); else passed++;
    total++; if (if_ins !== 32'h0) $display("FAIL reset_if_ins got %h want 0", if_ins); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid got %b want 0", if_valid); else passed++;
    total++; if (fetch_count !== 32'h0) $display("FAIL reset_count got %0d want 0", fetch_count); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else passed++;
    total++; if (rom_addr !== 10'd0) $display("FAIL reset_rom_addr got %h want 0", rom_addr); else passed++;
    total++; if (rom_sel !== 1'b1) $display("FAIL reset_rom_sel got %b want 1", rom_sel); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_ins [4];
    exp_ins[0] = 32'h11; exp_ins[1] = 32'h22; exp_ins[2] = 32'h33; exp_ins[3] = 32'h44;
    for (int i = 0; i < 4; i++) rom[i] = exp_ins[i];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0);
      total++; if (if_pc !== 32'(i * 4)) $display("FAIL seq_if_pc[%0d] got %h want %h", i, if_pc, i * 4); else passed++;
      total++; if (if_ins !== exp_ins[i]) $display("FAIL seq_if_ins[%0d] got %h want %h", i, if_ins, exp_ins[i]); else passed++;
      total++; if (if_valid !== 1'b1) $display("FAIL seq_if_valid[%0d] got %b want 1", i, if_valid); else passed++;
    end
    total++; if (fetch_count !== 32'd4) $display("FAIL seq_count got %0d want 4", fetch_count); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);   // pc now 8, IF/ID holds word 1
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      total++; if (if_pc !== 32'h4) $display("FAIL stall_if_pc[%0d] got %h want 4", i, if_pc); else passed++;
      total++; if (if_ins !== rom[1]) $display("FAIL stall_if_ins[%0d] got %h want %h", i, if_ins, rom[1]); else passed++;
      total++; if (rom_sel !== 1'b0) $display("FAIL stall_rom_sel[%0d] got %b want 0", i, rom_sel); else passed++;
    end
    cycle(0, 0, 0, 0);
    total++; if (if_pc !== 32'h4) $display("FAIL stall_release_hold got %h want 4", if_pc); else passed++;
    total++; if (rom_sel !== 1'b1 || rom_addr !== 10'd2) $display("FAIL stall_release_rom got sel %b addr %0d want 1/2", rom_sel, rom_addr); else passed++;
    cycle(0, 0, 0, 0);
    total++; if (if_pc !== 32'h8) $display("FAIL stall_after_pc8 got %h want 8", if_pc); else passed++;
    total++; if (if_ins !== rom[2]) $display("FAIL stall_after_ins got %h want %h", if_ins, rom[2]); else passed++;
    cycle(0, 0, 0, 0);
    total++; if (if_pc !== 32'hC) $display("FAIL stall_after_pcC got %h want C", if_pc); else passed++;
    total++; if (fetch_count !== 32'd4) $display("FAIL stall_count got %0d want 4", fetch_count); else passed++;
  endtask

  task automatic test_redirect_stall();
    cycle(0, 1, 32'h40, 1);
    total++; if (if_valid !== 1'b0) $display("FAIL redir_if_valid got %b want 0", if_valid); else passed++;
    total++; if (if_ins !== 32'h0) $display("FAIL redir_if_ins got %h want 0", if_ins); else passed++;
    total++; if (rom_addr !== 10'h10 || rom_sel !== 1'b1) $display("FAIL redir_pc got addr %h sel %b want 10/1", rom_addr, rom_sel); else passed++;
    cycle(0, 0, 0, 0);
    total++; if (if_pc !== 32'h40) $display("FAIL redir_if_pc got %h want 40", if_pc); else passed++;
    total++; if (if_ins !== rom[16] || if_valid !== 1'b1) $display("FAIL redir_fetch got %h/%b want %h/1", if_ins, if_valid, rom[16]); else passed++;
  endtask

  task automatic test_out_of_range();
    cycle(0, 1, 32'h1000, 0);
    total++; if (rom_sel !== 1'b0) $display("FAIL oor_rom_sel got %b want 0", rom_sel); else passed++;
    cycle(0, 0, 0, 0);
    total++; if (if_pc !== 32'h1000 || if_ins !== 32'h0 || if_valid !== 1'b1)
      $display("FAIL oor_nop got pc %h ins %h v %b want 1000/0/1", if_pc, if_ins, if_valid); else passed++;
    cycle(0, 1, 32'h2, 0);
    total++; if (rom_sel !== 1'b0) $display("FAIL misalign_rom_sel got %b want 0", rom_sel); else passed++;
    cycle(0, 0, 0, 0);
    total++; if (if_pc !== 32'h2 || if_ins !== 32'h0 || if_valid !== 1'b1)
      $display("FAIL misalign_nop got pc %h ins %h v %b want 2/0/1", if_pc, if_ins, if_valid); else passed++;
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 0);
    total++; if (if_pc !== 32'hFFFF_FFFC || if_ins !== 32'h0) $display("FAIL wrap_fetch got pc %h ins %h want fffffffc/0", if_pc, if_ins); else passed++;
    total++; if (rom_addr !== 10'd0 || rom_sel !== 1'b1) $display("FAIL wrap_pc got addr %h sel %b want 0/1", rom_addr, rom_sel); else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      total++; if (halted !== 1'b1 || if_valid !== 1'b0) $display("FAIL halt_flags[%0d] got halted %b v %b want 1/0", i, halted, if_valid); else passed++;
      total++; if (rom_addr !== 10'd4 || rom_sel !== 1'b0) $display("FAIL halt_pc[%0d] got addr %h sel %b want 4/0", i, rom_addr, rom_sel); else passed++;
      total++; if (fetch_count !== 32'd4) $display("FAIL halt_count[%0d] got %0d want 4", i, fetch_count); else passed++;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h80, 1'($urandom_range(0, 1)));
    end
    do_reset();
    total++; if (halted !== 1'b0 || rom_addr !== 10'd0) $display("FAIL halt_reset got halted %b addr %h want 0/0", halted, rom_addr); else passed++;
  endtask

  task automatic test_async_reset_stall();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #2 rst = 1'b1;
    stall = 1'b0;
    #1;
    total++; if (if_pc !== 32'h0 || if_ins !== 32'h0 || if_valid !== 1'b0)
      $display("FAIL async_rst_ifid got pc %h ins %h v %b want 0/0/0", if_pc, if_ins, if_valid); else passed++;
    total++; if (fetch_count !== 32'h0 || halted !== 1'b0 || rom_addr !== 10'd0)
      $display("FAIL async_rst_state got cnt %0d halted %b addr %h want 0/0/0", fetch_count, halted, rom_addr); else passed++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 0, 0, 0);
    total++; if (if_pc !== 32'h0 || if_ins !== rom[0] || if_valid !== 1'b1)
      $display("FAIL async_rst_first got pc %h ins %h v %b want 0/%h/1", if_pc, if_ins, if_valid, rom[0]); else passed++;
  endtask

  task automatic test_random();
    logic        r;
    logic        s;
    logic        h;
    logic [31:0] rpc;
    logic [108:0] got;
    logic [108:0] exp;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      h = (n == 390);
      case ($urandom_range(0, 3))
        0:       rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        1:       rpc = $urandom;
        2:       rpc = 32'h0000_0FF0 + 32'($urandom_range(0, 7) * 4);
        default: rpc = 32'($urandom_range(0, 63) * 4);
      endcase
      cycle(h, r, rpc, s);
      got = {if_pc, if_ins, if_valid, fetch_count, halted, rom_sel, rom_addr};
      exp = {m_if_pc, m_if_ins, m_valid, m_cnt, m_halted, m_sel(), m_pc[11:2]};
      total++; if (got !== exp) $display("FAIL random[%0d] got %h want %h", n, got, exp); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
    total = 0; passed = 0;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_out_of_range();
    test_halt();
    test_async_reset_stall();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
